// File: rtl/shake_arbiter.sv
// ---------------------------------------------------------------------------
// shake_arbiter
//
// Shares one SHAKE core between NUM_REQ clients. Each client drives a private
// copy of the core's 32-bit valid/ready streaming interface. When the arbiter
// is idle, it picks a requester in round-robin order. The grant then stays
// locked until the owner pulses force_done. This keeps one client's absorb and
// squeeze phases from interleaving with another client's.
//
// Ports
//   clk               : clock, all state updates on the rising edge
//   rst               : asynchronous active-low reset
//   req_din_valid     : per-client input valid (also acts as the request)
//   req_din           : per-client input words, client i at [i*W +: W]
//   req_din_ready     : per-client input ready (owner only)
//   req_dout_valid    : per-client output valid (owner only)
//   req_dout_ready    : per-client output ready
//   req_dout          : core output word, broadcast to every client
//   req_force_done    : per-client end-of-transaction pulse
//   din_valid_shake   : to core, input valid
//   din_shake         : to core, input word
//   din_ready_shake   : from core, input ready
//   dout_valid_shake  : from core, output valid
//   dout_shake        : from core, output word
//   dout_ready_shake  : to core, output ready
//   force_done_shake  : to core, end-of-transaction pulse
//   grant             : registered one-hot owner, zero when idle
//   busy              : registered, high while a transaction is open
//   words_in          : words absorbed in the current or last transaction
//   words_out         : words squeezed in the current or last transaction
// ---------------------------------------------------------------------------
module shake_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int W       = 32,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_din_valid,
  input  logic [NUM_REQ*W-1:0] req_din,
  output logic [NUM_REQ-1:0]   req_din_ready,
  output logic [NUM_REQ-1:0]   req_dout_valid,
  input  logic [NUM_REQ-1:0]   req_dout_ready,
  output logic [W-1:0]         req_dout,
  input  logic [NUM_REQ-1:0]   req_force_done,
  output logic                 din_valid_shake,
  output logic [W-1:0]         din_shake,
  input  logic                 din_ready_shake,
  input  logic                 dout_valid_shake,
  input  logic [W-1:0]         dout_shake,
  output logic                 dout_ready_shake,
  output logic                 force_done_shake,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [CNT_W-1:0]     words_in,
  output logic [CNT_W-1:0]     words_out
);

  localparam int LAST_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 busy_q;
  logic [LAST_W-1:0]    last_q;
  logic [CNT_W-1:0]     words_in_q;
  logic [CNT_W-1:0]     words_out_q;

  logic                 sel_found;
  logic [LAST_W-1:0]    sel_idx;
  logic [NUM_REQ-1:0]   sel_onehot;
  logic                 din_hs;
  logic                 dout_hs;

  // Round-robin pick. The scan starts at the slot after the last owner and
  // wraps modulo NUM_REQ. The first requester found wins.
  // NOTE: every signal written in an always_comb gets a default at the top.
  // Without it, some path leaves the signal unassigned and a latch is inferred.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!sel_found && req_din_valid[(int'(last_q) + k) % NUM_REQ]) begin
        sel_found = 1'b1;
        sel_idx   = LAST_W'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  assign sel_onehot = NUM_REQ'(1) << sel_idx;

  // Owner mux. grant_q is one-hot while busy and all-zero while idle. When
  // idle, no branch fires and every core-facing output stays at 0.
  always_comb begin
    din_valid_shake  = 1'b0;
    din_shake        = '0;
    dout_ready_shake = 1'b0;
    force_done_shake = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        din_valid_shake  = req_din_valid[i];
        din_shake        = req_din[i*W +: W];
        dout_ready_shake = req_dout_ready[i];
        force_done_shake = req_force_done[i];
      end
    end
  end

  assign req_din_ready  = grant_q & {NUM_REQ{din_ready_shake}};
  assign req_dout_valid = grant_q & {NUM_REQ{dout_valid_shake}};
  assign req_dout       = dout_shake;

  assign din_hs  = din_valid_shake & din_ready_shake;
  assign dout_hs = dout_valid_shake & dout_ready_shake;

  // After reset, last points at the final client, so client 0 wins the
  // first arbitration.
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      last_q      <= LAST_W'(NUM_REQ - 1);
      words_in_q  <= '0;
      words_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            state_q     <= BUSY;
            grant_q     <= sel_onehot;
            busy_q      <= 1'b1;
            last_q      <= sel_idx;
            words_in_q  <= '0;
            words_out_q <= '0;
          end
        end
        BUSY: begin
          // A handshake in the same cycle as force_done is still counted.
          if (din_hs && (words_in_q != {CNT_W{1'b1}})) begin
            words_in_q <= words_in_q + CNT_W'(1);
          end
          if (dout_hs && (words_out_q != {CNT_W{1'b1}})) begin
            words_out_q <= words_out_q + CNT_W'(1);
          end
          // Only the owner's force_done reaches force_done_shake.
          if (force_done_shake) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign words_in  = words_in_q;
  assign words_out = words_out_q;

endmodule
